// File: rtl/din_bank_router.sv
// Packs DIN_W-bit beats into DOUT_W-bit words and routes whole rows to NUM_BANKS BRAM write ports.
// Defining DIN_ROUTE_STALL_CNT_EN builds the starved-cycle counter; otherwise stall_cnt is tied to 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | after reset, waiting for the first start pulse
// ST_RUN    | accepting beats and issuing BRAM writes
// ST_DONE   | final write of the last bank issued, waiting for a restart
module din_bank_router #(
  parameter int DIN_W         = 32,
  parameter int DOUT_W        = 64,
  parameter int BEATS_PER_ROW = 384,
  parameter int ROWS_PER_BANK = 4,
  parameter int NUM_BANKS     = 16,
  parameter int ADDR_W        = 14
) (
  input  logic                 axi_ACLK,
  input  logic                 axi_ARESET,
  input  logic                 stage_start,
  input  logic [DIN_W-1:0]     s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [NUM_BANKS-1:0] bram_wea,
  output logic [ADDR_W-1:0]    bram_addra,
  output logic [DOUT_W-1:0]    bram_dina,
  output logic [NUM_BANKS-1:0] bram_wdone,
  output logic                 frame_done,
  output logic                 err_last,
  output logic [31:0]          stall_cnt
);

  localparam int PACK    = DOUT_W / DIN_W;
  localparam int BEAT_CW = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int PACK_CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int ROW_CW  = (ROWS_PER_BANK > 1) ? $clog2(ROWS_PER_BANK) : 1;
  localparam int BANK_CW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state;
  logic               stage_start_q;
  logic               start_pulse;
  logic               accept;
  logic               row_end;
  logic               word_done;
  logic               bank_end;
  logic               last_bank;
  logic [BEAT_CW-1:0] beat_idx;
  logic [PACK_CW-1:0] pack_idx;
  logic [ROW_CW-1:0]  row_cnt;
  logic [BANK_CW-1:0] bank;
  logic [ADDR_W-1:0]  addr;
  logic [DOUT_W-1:0]  pack_buf;
  logic [DOUT_W-1:0]  word_next;

  assign start_pulse = stage_start & ~stage_start_q;
  assign s_ready     = (state == ST_RUN);
  // A beat offered in the start-pulse cycle belongs to the aborted frame and is dropped.
  assign accept      = s_ready & s_valid & ~start_pulse;
  assign row_end     = (beat_idx == BEAT_CW'(BEATS_PER_ROW - 1));
  assign word_done   = (pack_idx == PACK_CW'(PACK - 1));
  assign bank_end    = row_end & (row_cnt == ROW_CW'(ROWS_PER_BANK - 1));
  assign last_bank   = (bank == BANK_CW'(NUM_BANKS - 1));

  // First beat of a word lands in the low bits.
  always_comb begin
    word_next = '0;
    for (int k = 0; k < PACK; k++) begin
      word_next[k*DIN_W +: DIN_W] = (PACK_CW'(k) == pack_idx) ? s_data : pack_buf[k*DIN_W +: DIN_W];
    end
  end

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      state         <= ST_IDLE;
      stage_start_q <= 1'b0;
      beat_idx      <= '0;
      pack_idx      <= '0;
      row_cnt       <= '0;
      bank          <= '0;
      addr          <= '0;
      pack_buf      <= '0;
      bram_wea      <= '0;
      bram_addra    <= '0;
      bram_dina     <= '0;
      bram_wdone    <= '0;
      frame_done    <= 1'b0;
      err_last      <= 1'b0;
    end else begin
      stage_start_q <= stage_start;
      bram_wea      <= '0;
      if (start_pulse) begin
        state      <= ST_RUN;
        beat_idx   <= '0;
        pack_idx   <= '0;
        row_cnt    <= '0;
        bank       <= '0;
        addr       <= '0;
        pack_buf   <= '0;
        bram_wdone <= '0;
        frame_done <= 1'b0;
        err_last   <= 1'b0;
      end else if (accept) begin
        if (s_last != row_end) begin
          err_last <= 1'b1;
        end
        beat_idx <= row_end ? '0 : beat_idx + 1'b1;
        if (row_end) begin
          row_cnt <= (row_cnt == ROW_CW'(ROWS_PER_BANK - 1)) ? '0 : row_cnt + 1'b1;
        end
        if (word_done) begin
          pack_idx   <= '0;
          pack_buf   <= '0;
          bram_wea   <= NUM_BANKS'(1) << bank;
          bram_addra <= addr;
          bram_dina  <= word_next;
          // Rows end on word boundaries, so a bank always closes on a completed word.
          if (bank_end) begin
            bram_wdone[bank] <= 1'b1;
            addr             <= '0;
            if (last_bank) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              bank       <= '0;
            end else begin
              bank <= bank + 1'b1;
            end
          end else begin
            addr <= addr + 1'b1;
          end
        end else begin
          pack_idx <= pack_idx + 1'b1;
          pack_buf <= word_next;
        end
      end
    end
  end

`ifdef DIN_ROUTE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge axi_ACLK) begin
    if (axi_ARESET) begin
      stall_q <= '0;
    end else if (start_pulse) begin
      stall_q <= '0;
    end else if ((state == ST_RUN) && !s_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_din_bank_router.sv
// Bench for din_bank_router: default build plus a small PACK=1, three-bank build, each checked every cycle
// against a beat-count model of the routing rules.
module tb_din_bank_router;

`ifdef DIN_ROUTE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  localparam int LOGN = 32768;

  logic axi_ACLK = 1'b0;
  always #5 axi_ACLK = ~axi_ACLK;
  logic axi_ARESET;

  logic        a_start, a_valid, a_last;
  logic [31:0] a_data;
  logic        a_ready;
  logic [15:0] a_wea;
  logic [13:0] a_addr;
  logic [63:0] a_dina;
  logic [15:0] a_wdone;
  logic        a_fdone, a_err;
  logic [31:0] a_stall;

  logic        b_start, b_valid, b_last;
  logic [31:0] b_data;
  logic        b_ready;
  logic [2:0]  b_wea;
  logic [3:0]  b_addr;
  logic [31:0] b_dina;
  logic [2:0]  b_wdone;
  logic        b_fdone, b_err;
  logic [31:0] b_stall;

  din_bank_router dut_a (
    .axi_ACLK(axi_ACLK), .axi_ARESET(axi_ARESET), .stage_start(a_start),
    .s_data(a_data), .s_valid(a_valid), .s_last(a_last), .s_ready(a_ready),
    .bram_wea(a_wea), .bram_addra(a_addr), .bram_dina(a_dina), .bram_wdone(a_wdone),
    .frame_done(a_fdone), .err_last(a_err), .stall_cnt(a_stall)
  );

  din_bank_router #(
    .DIN_W(32), .DOUT_W(32), .BEATS_PER_ROW(8), .ROWS_PER_BANK(2), .NUM_BANKS(3), .ADDR_W(4)
  ) dut_b (
    .axi_ACLK(axi_ACLK), .axi_ARESET(axi_ARESET), .stage_start(b_start),
    .s_data(b_data), .s_valid(b_valid), .s_last(b_last), .s_ready(b_ready),
    .bram_wea(b_wea), .bram_addra(b_addr), .bram_dina(b_dina), .bram_wdone(b_wdone),
    .frame_done(b_fdone), .err_last(b_err), .stall_cnt(b_stall)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk = 1'b0;
  int gap_cnt = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model state: n counts beats accepted in the current frame; everything else follows from it.
  typedef struct {
    bit          run;
    bit          prev;
    int          n;
    logic [63:0] word;
    bit          err;
    logic [15:0] wdone;
    bit          fdone;
    logic [31:0] stall;
    logic [15:0] p_wea;
    int          p_addr;
    logic [63:0] p_data;
  } mstate_t;

  function automatic mstate_t mreset();
    mstate_t r;
    r.run = 0; r.prev = 0; r.n = 0; r.word = '0; r.err = 0; r.wdone = '0;
    r.fdone = 0; r.stall = '0; r.p_wea = '0; r.p_addr = 0; r.p_data = '0;
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t m, input int bpr, input int pack, input int rpb,
                                         input int nb, input int dinw, input bit rst, input bit st,
                                         input bit vld, input bit lst, input logic [63:0] dat);
    mstate_t r;
    int wpb, w, bk, k;
    r = m;
    r.p_wea = '0;
    if (rst) return mreset();
    wpb = rpb * bpr / pack;
    r.prev = st;
    if (st && !m.prev) begin
      r.run = 1; r.n = 0; r.word = '0; r.err = 0; r.wdone = '0; r.fdone = 0; r.stall = '0;
    end else if (m.run) begin
      if (!vld) begin
        if (m.stall != 32'hFFFF_FFFF) r.stall = m.stall + 1;
      end else begin
        if (lst != ((m.n % bpr) == bpr - 1)) r.err = 1;
        k = m.n % pack;
        if (k == 0) r.word = '0;
        r.word = r.word | (dat << (k * dinw));
        r.n = m.n + 1;
        if (r.n % pack == 0) begin
          w = r.n / pack - 1;
          bk = w / wpb;
          r.p_wea = 16'(1) << bk;
          r.p_addr = w % wpb;
          r.p_data = r.word;
          if (w % wpb == wpb - 1) begin
            r.wdone[bk] = 1'b1;
            if (bk == nb - 1) begin
              r.fdone = 1;
              r.run = 0;
            end
          end
        end
      end
    end
    return r;
  endfunction

  mstate_t ma = mreset();
  mstate_t mb = mreset();

  logic [15:0] a_log_wea  [LOGN];
  logic [13:0] a_log_addr [LOGN];
  logic [63:0] a_log_data [LOGN];
  int a_wr_total = 0;
  logic [2:0]  b_log_wea  [64];
  logic [3:0]  b_log_addr [64];
  int b_wr_total = 0;

  always @(negedge axi_ACLK) begin
    if (chk) begin
      cmp("a_s_ready", a_ready, ma.run);
      cmp("a_wea", a_wea, ma.p_wea);
      if (ma.p_wea != 0) begin
        cmp("a_addra", a_addr, ma.p_addr);
        cmp("a_dina", a_dina, ma.p_data);
      end
      cmp("a_wdone", a_wdone, ma.wdone);
      cmp("a_frame_done", a_fdone, ma.fdone);
      cmp("a_err_last", a_err, ma.err);
      cmp("a_stall_cnt", a_stall, STALL_EN ? ma.stall : 32'd0);
    end
    if (a_wea != 0) begin
      a_log_wea[a_wr_total % LOGN]  = a_wea;
      a_log_addr[a_wr_total % LOGN] = a_addr;
      a_log_data[a_wr_total % LOGN] = a_dina;
      a_wr_total++;
    end
    ma = model_next(ma, 384, 2, 4, 16, 32, axi_ARESET, a_start, a_valid, a_last, {32'h0, a_data});
  end

  always @(negedge axi_ACLK) begin
    if (chk) begin
      cmp("b_s_ready", b_ready, mb.run);
      cmp("b_wea", b_wea, mb.p_wea);
      if (mb.p_wea != 0) begin
        cmp("b_addra", b_addr, mb.p_addr);
        cmp("b_dina", b_dina, mb.p_data);
      end
      cmp("b_wdone", b_wdone, mb.wdone);
      cmp("b_frame_done", b_fdone, mb.fdone);
      cmp("b_err_last", b_err, mb.err);
      cmp("b_stall_cnt", b_stall, STALL_EN ? mb.stall : 32'd0);
    end
    if (b_wea != 0) begin
      if (b_wr_total < 64) begin
        b_log_wea[b_wr_total]  = b_wea;
        b_log_addr[b_wr_total] = b_addr;
      end
      b_wr_total++;
    end
    mb = model_next(mb, 8, 1, 2, 3, 32, axi_ARESET, b_start, b_valid, b_last, {32'h0, b_data});
  end

  task automatic cyc();
    @(posedge axi_ACLK);
    #2;
  endtask

  task automatic pulse_a();
    a_start = 1'b1; a_valid = 1'b0;
    cyc();
    a_start = 1'b0;
  endtask

  task automatic send_a(input int first, input int count, input bit gaps, input int err_beat);
    int i, budget;
    i = first;
    budget = count * 4 + 1000;
    while (i < first + count) begin
      a_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_data  = 32'h1000_0000 + 32'(i);
      a_last  = ((i % 384) == 383) || (i == err_beat);
      if (a_valid && a_ready) i++;
      else if (!a_valid && a_ready) gap_cnt++;
      cyc();
      budget--;
      if (budget == 0) begin
        n_checks++; n_errors++;
        $display("FAIL send_a_timeout: accepted %0d, required %0d", i - first, count);
        break;
      end
    end
    a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic check_frame(input int base, input string tag);
    for (int j = 0; j < 12288; j++) begin
      cmp({tag, "_wea"}, a_log_wea[base + j], 64'(16'(1) << (j / 768)));
      cmp({tag, "_addr"}, a_log_addr[base + j], 64'(j % 768));
      cmp({tag, "_data"}, a_log_data[base + j],
          {32'h1000_0000 + 32'(2 * j + 1), 32'h1000_0000 + 32'(2 * j)});
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, bi, budget;
    axi_ARESET = 1'b1;
    a_start = 0; a_valid = 0; a_last = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_last = 0; b_data = '0;
    repeat (3) cyc();
    chk = 1'b1;
    cmp("rst_s_ready", a_ready, 0);
    cmp("rst_wea", a_wea, 0);
    cmp("rst_wdone", a_wdone, 0);
    axi_ARESET = 1'b0;
    cyc();

    // Small build: PACK = 1, 3 banks of 2 rows of 8 beats.
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    bi = 0; budget = 200;
    while (bi < 48 && budget > 0) begin
      b_valid = 1'b1;
      b_data  = 32'h2000_0000 + 32'(bi);
      b_last  = (bi % 8) == 7;
      if (b_ready) bi++;
      cyc();
      budget--;
    end
    cmp("b_beats_accepted", bi, 48);
    b_valid = 1'b0; b_last = 1'b0;
    cyc(); cyc();
    cmp("b_writes", b_wr_total, 48);
    cmp("b_frame_done_lit", b_fdone, 1);
    cmp("b_wdone_lit", b_wdone, 3'b111);
    for (int j = 0; j < 48; j++) begin
      cmp("b_log_bank", b_log_wea[j], 64'(3'(1) << (j / 16)));
      cmp("b_log_addr", b_log_addr[j], 64'(j % 16));
    end
    b_valid = 1'b1; b_data = 32'hDEAD_BEEF;
    repeat (4) begin
      cmp("b_ready_after_done", b_ready, 0);
      cyc();
    end
    b_valid = 1'b0;
    cmp("b_no_write_after_done", b_wr_total, 48);

    // Nominal frame, s_valid held high.
    pulse_a();
    base = a_wr_total;
    send_a(0, 24576, 1'b0, -1);
    cyc(); cyc();
    cmp("nom_writes", a_wr_total - base, 12288);
    cmp("nom_first_dina", a_log_data[base], 64'h1000_0001_1000_0000);
    cmp("nom_last_wea", a_log_wea[base + 12287], 16'h8000);
    cmp("nom_last_addr", a_log_addr[base + 12287], 767);
    cmp("nom_frame_done", a_fdone, 1);
    cmp("nom_wdone", a_wdone, 16'hFFFF);
    cmp("nom_err_last", a_err, 0);
    check_frame(base, "nom");

    // Same frame with random gaps, restarted from DONE.
    pulse_a();
    base = a_wr_total;
    gap_cnt = 0;
    send_a(0, 24576, 1'b1, -1);
    cmp("gap_stall_cnt", a_stall, STALL_EN ? gap_cnt : 0);
    cyc(); cyc();
    cmp("gap_writes", a_wr_total - base, 12288);
    check_frame(base, "gap");

    // Restart mid-row while an odd beat is offered.
    pulse_a();
    base = a_wr_total;
    send_a(0, 1001, 1'b0, -1);
    a_start = 1'b1; a_valid = 1'b1; a_data = 32'h1000_0000 + 32'd1001; a_last = 1'b0;
    cyc();
    a_start = 1'b0; a_valid = 1'b0;
    cmp("restart_partial_writes", a_wr_total - base, 500);
    cmp("restart_wdone", a_wdone, 0);
    cmp("restart_ready", a_ready, 1);
    cyc();
    base2 = a_wr_total;
    cmp("restart_no_write", base2 - base, 500);
    send_a(0, 4, 1'b0, -1);
    cyc();
    cmp("restart_writes", a_wr_total - base2, 2);
    cmp("restart_first_wea", a_log_wea[base2], 1);
    cmp("restart_first_addr", a_log_addr[base2], 0);
    cmp("restart_first_dina", a_log_data[base2], 64'h1000_0001_1000_0000);

    // Stray s_last on beat 100 of row 0.
    pulse_a();
    base = a_wr_total;
    send_a(0, 100, 1'b0, 100);
    cmp("err_before", a_err, 0);
    send_a(100, 1, 1'b0, 100);
    cmp("err_after", a_err, 1);
    send_a(101, 285, 1'b0, 100);
    cyc();
    cmp("err_writes", a_wr_total - base, 193);
    cmp("err_row1_first_addr", a_log_addr[base + 192], 192);
    cmp("err_row1_first_wea", a_log_wea[base + 192], 1);

    // Reset mid-frame.
    axi_ARESET = 1'b1; a_valid = 1'b1; a_data = 32'h5555_AAAA;
    cyc();
    cmp("rstmid_ready", a_ready, 0);
    cmp("rstmid_wea", a_wea, 0);
    cmp("rstmid_addra", a_addr, 0);
    cmp("rstmid_dina", a_dina, 0);
    cmp("rstmid_err", a_err, 0);
    cmp("rstmid_stall", a_stall, 0);
    axi_ARESET = 1'b0;
    base = a_wr_total;
    repeat (5) cyc();
    a_valid = 1'b0;
    cmp("rstmid_no_write", a_wr_total - base, 0);
    cmp("rstmid_idle_ready", a_ready, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
